shift_reg_univ: RTL and testbench

Parametrised universal shift register: the next generation of the team's 4-bit load/shift-right/shift-left register. Adds configurable width, logical/rotate/arithmetic fill modes, and an optional multi-cycle burst-shift engine with a busy/done handshake. Used wherever a datapath needs a serialiser, barrel-less multi-bit shift or rotating mask register.

---
 rtl/shift_reg_univ.sv | 160 ++++++++++++++++
 tb/tb_shift_reg_univ.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_univ.sv
// rtl/shift_reg_univ.sv - parametrised universal shift register (load, shift, rotate, arithmetic)
// Define SHIFT_REG_UNIV_BURST_EN to build the multi-cycle burst-shift engine (start/busy/done).
module shift_reg_univ #(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D,
  input  logic             D_sr,
  input  logic             D_sl,
  input  logic             ld,
  input  logic             sr,
  input  logic             sl,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             dir,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] Q,
  output logic             so,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] MODE_ROT = 2'b01;
  localparam logic [1:0] MODE_ARI = 2'b10;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic             so_r;
  logic             so_nxt;

  // Result is {bit leaving the register, shifted register}; mode 11 falls into the logical default.
  function automatic logic [WIDTH:0] shift1(
    input logic [WIDTH-1:0] q,
    input logic             right,
    input logic [1:0]       m,
    input logic             fill_r,
    input logic             fill_l
  );
    logic fin;
    if (right) begin
      case (m)
        MODE_ROT: fin = q[0];
        MODE_ARI: fin = q[WIDTH-1];
        default:  fin = fill_r;
      endcase
      return {q[0], fin, q[WIDTH-1:1]};
    end else begin
      case (m)
        MODE_ROT: fin = q[WIDTH-1];
        MODE_ARI: fin = 1'b0;
        default:  fin = fill_l;
      endcase
      return {q[WIDTH-1], q[WIDTH-2:0], fin};
    end
  endfunction

`ifdef SHIFT_REG_UNIV_BURST_EN
  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_nxt;
  logic          bdir;
  logic          bdir_nxt;
  logic [1:0]    bmode;
  logic [1:0]    bmode_nxt;
  logic          done_r;
  logic          done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      bdir   <= 1'b0;
      bmode  <= 2'b00;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      bdir   <= bdir_nxt;
      bmode  <= bmode_nxt;
      done_r <= done_nxt;
    end
  end

  assign busy = (state == RUN);
  assign done = done_r;
`else
  logic unused_burst;
  assign unused_burst = ^{start, dir, amt};
  assign busy = 1'b0;
  assign done = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r  <= '0;
      so_r <= 1'b0;
    end else begin
      q_r  <= q_nxt;
      so_r <= so_nxt;
    end
  end

  // Priority: ld > running burst > start > sr > sl.
  always_comb begin
    q_nxt  = q_r;
    so_nxt = so_r;
`ifdef SHIFT_REG_UNIV_BURST_EN
    state_nxt = state;
    cnt_nxt   = cnt;
    bdir_nxt  = bdir;
    bmode_nxt = bmode;
    done_nxt  = 1'b0;
`endif
    if (ld) begin
      q_nxt = D;
`ifdef SHIFT_REG_UNIV_BURST_EN
      state_nxt = IDLE;
      cnt_nxt   = '0;
`endif
    end
`ifdef SHIFT_REG_UNIV_BURST_EN
    else if (state == RUN) begin
      {so_nxt, q_nxt} = shift1(q_r, ~bdir, bmode, D_sr, D_sl);
      cnt_nxt         = cnt - AW'(1);
      if (cnt == AW'(1)) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
    end else if (start) begin
      bdir_nxt  = dir;
      bmode_nxt = mode;
      if (amt == '0) begin
        done_nxt = 1'b1;
      end else begin
        {so_nxt, q_nxt} = shift1(q_r, ~dir, mode, D_sr, D_sl);
        cnt_nxt         = amt - AW'(1);
        if (amt == AW'(1)) begin
          done_nxt = 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
    end
`endif
    else if (sr) begin
      {so_nxt, q_nxt} = shift1(q_r, 1'b1, mode, D_sr, D_sl);
    end else if (sl) begin
      {so_nxt, q_nxt} = shift1(q_r, 1'b0, mode, D_sr, D_sl);
    end
  end

  assign Q  = q_r;
  assign so = so_r;

endmodule

// File: tb/tb_shift_reg_univ.sv
// tb/tb_shift_reg_univ.sv - scoreboard bench for shift_reg_univ (WIDTH=8)
// Expectations follow the build: SHIFT_REG_UNIV_BURST_EN selects burst-engine results.
module tb_shift_reg_univ;

`ifdef SHIFT_REG_UNIV_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] D;
  logic       D_sr;
  logic       D_sl;
  logic       ld;
  logic       sr;
  logic       sl;
  logic [1:0] mode;
  logic       start;
  logic       dir;
  logic [3:0] amt;
  logic [7:0] Q;
  logic       so;
  logic       busy;
  logic       done;

  shift_reg_univ #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .D(D), .D_sr(D_sr), .D_sl(D_sl),
    .ld(ld), .sr(sr), .sl(sl), .mode(mode), .start(start), .dir(dir),
    .amt(amt), .Q(Q), .so(so), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [7:0] q;
    logic       so;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t  sb[$];
  string nm_q[$];
  event  mon_ev;
  int    n_total = 0;
  int    n_pass  = 0;

  logic [7:0] rot_q  [0:8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
  logic       rot_so [0:8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: outputs are registered, so compare 1 time unit after each edge (or on a reset probe).
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(posedge clk or mon_ev);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n = nm_q.pop_front();
        chk({n, ".Q"},    Q,              e.q);
        chk({n, ".so"},   {7'b0, so},     {7'b0, e.so});
        chk({n, ".busy"}, {7'b0, busy},   {7'b0, e.busy});
        chk({n, ".done"}, {7'b0, done},   {7'b0, e.done});
      end
    end
  end

  task automatic step(input string nm, input logic l, input logic [7:0] d,
                      input logic r, input logic lft, input logic fr, input logic fl,
                      input logic [1:0] m, input logic st, input logic dr, input logic [3:0] a,
                      input logic [7:0] eq, input logic eso, input logic eb, input logic ed);
    ld = l; D = d; sr = r; sl = lft; D_sr = fr; D_sl = fl;
    mode = m; start = st; dir = dr; amt = a;
    sb.push_back('{q: eq, so: eso, busy: eb, done: ed});
    nm_q.push_back(nm);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input string nm, input logic [7:0] eq, input logic eso,
                      input logic eb, input logic ed);
    step(nm, 0, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0, 4'd0, eq, eso, eb, ed);
  endtask

  task automatic reset_probe(input string nm);
    sb.push_back('{q: 8'h00, so: 1'b0, busy: 1'b0, done: 1'b0});
    nm_q.push_back(nm);
    -> mon_ev;
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; ld = 0; D = 0; sr = 0; sl = 0; D_sr = 0; D_sl = 0;
    mode = 0; start = 0; dir = 0; amt = 0;
    #3 rst_n = 1'b0;
    #1 reset_probe("por");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // single-step load / shift across modes
    step("ld_a5",      1, 8'hA5, 0, 0, 0, 0, 2'b00, 0, 0, 4'd0, 8'hA5, 0, 0, 0);
    step("sr_log",     0, 8'h00, 1, 0, 1, 0, 2'b00, 0, 0, 4'd0, 8'hD2, 1, 0, 0);
    step("sl_log",     0, 8'h00, 0, 1, 0, 0, 2'b00, 0, 0, 4'd0, 8'hA4, 1, 0, 0);
    step("sr_pri_rot", 0, 8'h00, 1, 1, 0, 0, 2'b01, 0, 0, 4'd0, 8'h52, 0, 0, 0);
    step("sr_ari",     0, 8'h00, 1, 0, 0, 0, 2'b10, 0, 0, 4'd0, 8'h29, 0, 0, 0);
    step("sl_rsv",     0, 8'h00, 0, 1, 0, 1, 2'b11, 0, 0, 4'd0, 8'h53, 0, 0, 0);
    step("sl_ari",     0, 8'h00, 0, 1, 0, 1, 2'b10, 0, 0, 4'd0, 8'hA6, 0, 0, 0);
    step("sr_ari_neg", 0, 8'h00, 1, 0, 0, 0, 2'b10, 0, 0, 4'd0, 8'hD3, 0, 0, 0);
    idle("hold", 8'hD3, 0, 0, 0);
    step("sr_so1",     0, 8'h00, 1, 0, 0, 0, 2'b00, 0, 0, 4'd0, 8'h69, 1, 0, 0);
    step("ld_keep_so", 1, 8'h81, 0, 0, 0, 0, 2'b00, 0, 0, 4'd0, 8'h81, 1, 0, 0);

    // rotate-left burst of 3; mode/dir changed mid-burst must be ignored
    step("rot_b1", 0, 8'h00, 0, 0, 0, 0, 2'b01, 1, 1, 4'd3,
         BURST ? 8'h03 : 8'h81, 1, BURST, 0);
    step("rot_b2", 0, 8'h00, 0, 0, 0, 1, 2'b00, 0, 0, 4'd0,
         BURST ? 8'h06 : 8'h81, !BURST, BURST, 0);
    step("rot_b3", 0, 8'h00, 0, 0, 0, 1, 2'b00, 0, 0, 4'd0,
         BURST ? 8'h0C : 8'h81, !BURST, 0, BURST);
    idle("rot_idle", BURST ? 8'h0C : 8'h81, !BURST, 0, 0);

    // arithmetic-right burst of 4, then back-to-back amt=0 and amt=1
    step("ld_80", 1, 8'h80, 0, 0, 0, 0, 2'b00, 0, 0, 4'd0, 8'h80, !BURST, 0, 0);
    step("ari_b1", 0, 8'h00, 0, 0, 0, 0, 2'b10, 1, 0, 4'd4,
         BURST ? 8'hC0 : 8'h80, !BURST, BURST, 0);
    step("ari_b2", 0, 8'h00, 0, 0, 0, 0, 2'b01, 0, 0, 4'd0,
         BURST ? 8'hE0 : 8'h80, !BURST, BURST, 0);
    step("ari_b3", 0, 8'h00, 0, 0, 0, 0, 2'b01, 0, 0, 4'd0,
         BURST ? 8'hF0 : 8'h80, !BURST, BURST, 0);
    step("ari_b4", 0, 8'h00, 0, 0, 0, 0, 2'b01, 0, 0, 4'd0,
         BURST ? 8'hF8 : 8'h80, !BURST, 0, BURST);
    step("amt0", 0, 8'h00, 0, 0, 0, 0, 2'b00, 1, 0, 4'd0,
         BURST ? 8'hF8 : 8'h80, !BURST, 0, BURST);
    step("amt1", 0, 8'h00, 0, 0, 0, 1, 2'b00, 1, 1, 4'd1,
         BURST ? 8'hF1 : 8'h80, 1, 0, BURST);
    idle("amt1_idle", BURST ? 8'hF1 : 8'h80, 1, 0, 0);

    // abort by ld on the second busy cycle; sr during busy ignored, D_sl sampled live
    step("ld_01", 1, 8'h01, 0, 0, 0, 0, 2'b00, 0, 0, 4'd0, 8'h01, 1, 0, 0);
    step("ab_b1", 0, 8'h00, 0, 0, 0, 0, 2'b00, 1, 1, 4'd5,
         BURST ? 8'h02 : 8'h01, !BURST, BURST, 0);
    step("ab_sr_ign", 0, 8'h00, 1, 0, 1, 1, 2'b00, 0, 0, 4'd0,
         BURST ? 8'h05 : 8'h80, !BURST, BURST, 0);
    step("ab_ld", 1, 8'h3C, 0, 0, 0, 0, 2'b00, 0, 0, 4'd0, 8'h3C, !BURST, 0, 0);
    idle("ab_idle1", 8'h3C, !BURST, 0, 0);
    idle("ab_idle2", 8'h3C, !BURST, 0, 0);

    // asynchronous reset in the middle of a rotate-right burst of 6
    step("rst_b1", 0, 8'h00, 0, 0, 0, 0, 2'b01, 1, 0, 4'd6,
         BURST ? 8'h1E : 8'h3C, !BURST, BURST, 0);
    idle("rst_b2", BURST ? 8'h0F : 8'h3C, !BURST, BURST, 0);
    idle("rst_b3", BURST ? 8'h87 : 8'h3C, 1, BURST, 0);
    rst_n = 1'b0;
    #1 reset_probe("rst_now");
    idle("rst_hold1", 8'h00, 0, 0, 0);
    idle("rst_hold2", 8'h00, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle($sformatf("rst_after%0d", i), 8'h00, 0, 0, 0);

    // burst longer than WIDTH: 9 rotations of 01
    step("ld_01b", 1, 8'h01, 0, 0, 0, 0, 2'b00, 0, 0, 4'd0, 8'h01, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step($sformatf("rot9_%0d", i), 0, 8'h00, 0, 0, 0, 0, 2'b01, i == 0, 1, 4'd9,
           BURST ? rot_q[i] : 8'h01, BURST ? rot_so[i] : 1'b0,
           BURST && (i < 8), BURST && (i == 8));
    end
    idle("rot9_idle", BURST ? 8'h02 : 8'h01, 0, 0, 0);

    #5;
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL sb_empty: got %0d pending expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
